// File: rtl/baud_pkg.sv
// Shared baud-rate constants and half-divisor math for the UART
// baud generators (receiver 16x, transmitter 1x).
package baud_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  // H = floor(round(f / (rate * os)) / 2), evaluated at elaboration
  function automatic int unsigned baud_half(
    input int unsigned clk_freq,
    input logic [1:0]  code,
    input int unsigned os
  );
    longint unsigned rate;
    longint unsigned div;
    longint unsigned n;
    case (code)
      BAUD_2400: rate = 64'd2400;
      BAUD_4800: rate = 64'd4800;
      BAUD_9600: rate = 64'd9600;
      default:   rate = 64'd19200;
    endcase
    div = rate * 64'(os);
    n   = (64'(clk_freq) + (div >> 1)) / div;
    return 32'(n >> 1);
  endfunction

endpackage

// File: rtl/baud_divider.sv
// Free-running half-period counter plus toggle flop; the half
// count (minus one) is a runtime input so the rate can change live.
module baud_divider #(
  parameter int unsigned CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] half_m1_i,
  output logic          clk_o,
  output logic          tick_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog_q, tog_d;
  logic          wrap;

  // >= so a drop to a faster rate never leaves the count stranded
  assign wrap = (cnt_q >= half_m1_i);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    tog_d = tog_q;
    if (wrap) begin
      cnt_d = '0;
      tog_d = ~tog_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tog_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tog_q <= tog_d;
    end
  end

  assign clk_o  = tog_q;
  assign tick_o = wrap & ~tog_q;

endmodule

// File: rtl/baud_gen_r.sv
// Receiver baud clock: square wave at rate x OVERSAMPLE.
// Optional baud_tick output under BAUD_GEN_R_TICK_EN.
module baud_gen_r
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 200_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
`ifdef BAUD_GEN_R_TICK_EN
  output logic       baud_tick,
`endif
  output logic       baud_clk
);

  localparam int unsigned H0 =
    baud_half(CLK_FREQ, BAUD_2400, OVERSAMPLE);
  localparam int unsigned H1 =
    baud_half(CLK_FREQ, BAUD_4800, OVERSAMPLE);
  localparam int unsigned H2 =
    baud_half(CLK_FREQ, BAUD_9600, OVERSAMPLE);
  localparam int unsigned H3 =
    baud_half(CLK_FREQ, BAUD_19200, OVERSAMPLE);

  localparam int unsigned HA = (H0 > H1) ? H0 : H1;
  localparam int unsigned HB = (H2 > H3) ? H2 : H3;
  localparam int unsigned HMAX = (HA > HB) ? HA : HB;
  localparam int unsigned CW =
    (HMAX > 1) ? $clog2(HMAX) : 1;

  logic [CW-1:0] half_m1;
  logic          tick;

  always_comb begin
    half_m1 = CW'(H3 - 1);
    unique case (baud_rate)
      BAUD_2400:  half_m1 = CW'(H0 - 1);
      BAUD_4800:  half_m1 = CW'(H1 - 1);
      BAUD_9600:  half_m1 = CW'(H2 - 1);
      BAUD_19200: half_m1 = CW'(H3 - 1);
    endcase
  end

  baud_divider #(
    .CW (CW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .half_m1_i (half_m1),
    .clk_o     (baud_clk),
    .tick_o    (tick)
  );

`ifdef BAUD_GEN_R_TICK_EN
  assign baud_tick = tick;
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

endmodule

// File: tb/tb_baud_gen_r.sv
// Self-checking bench for baud_gen_r: directed timing checks plus
// randomized rate/reset traffic against a cycle-level model.
module tb_baud_gen_r;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rate = 2'b00;
  logic       baud_clk;
`ifdef BAUD_GEN_R_TICK_EN
  logic       baud_tick;
  int         ticks = 0;
  int         t0;
`endif

  int checks = 0;
  int failures = 0;

  int   m_el = 0;
  logic m_clk = 1'b0;

  always #5 clk = ~clk;

  baud_gen_r dut (
    .clk       (clk),
    .rst       (rst),
    .baud_rate (rate),
`ifdef BAUD_GEN_R_TICK_EN
    .baud_tick (baud_tick),
`endif
    .baud_clk  (baud_clk)
  );

  function automatic int h_of(input logic [1:0] c);
    real r;
    case (c)
      2'd0:    r = 2400.0;
      2'd1:    r = 4800.0;
      2'd2:    r = 9600.0;
      default: r = 19200.0;
    endcase
    return $rtoi(200.0e6 / (r * 16.0) + 0.5) / 2;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Model: toggle once H cycles have elapsed since the last toggle
  task automatic step();
    logic exp_tick;
    @(posedge clk);
    if (!rst) begin
      m_el  = 0;
      m_clk = 1'b0;
    end else begin
      m_el++;
      if (m_el >= h_of(rate)) begin
        m_clk = ~m_clk;
        m_el  = 0;
      end
    end
    #1;
    chk("model", baud_clk, m_clk);
    exp_tick = rst && !m_clk && (m_el + 1 >= h_of(rate));
`ifdef BAUD_GEN_R_TICK_EN
    chk("tick", baud_tick, exp_tick);
    if (baud_tick === 1'b1) ticks++;
`endif
  endtask

  task automatic wait_lvl(
    input  logic v,
    input  int   lim,
    output int   n
  );
    n = 0;
    do begin
      step();
      n++;
    end while (baud_clk !== v && n < lim);
    if (baud_clk !== v) chk("timeout", baud_clk, v);
  endtask

  task automatic do_reset(input int cyc);
    rst   = 1'b0;
    m_el  = 0;
    m_clk = 1'b0;
    repeat (cyc) step();
    rst = 1'b1;
  endtask

  int n, hi, lo;
  int per [4] = '{5208, 2604, 1302, 650};

  initial begin
    rate = 2'($urandom_range(0, 3));
    repeat (10) begin
      step();
      chk("rst_clk", baud_clk, 0);
      chk("rst_cnt", 32'(dut.u_div.cnt_q), 0);
    end

    rate = 2'd2;
    rst  = 1'b1;
    wait_lvl(1'b1, 2000, n);
    chk("first_rise", n, 651);
`ifdef BAUD_GEN_R_TICK_EN
    t0 = ticks;
`endif
    for (int i = 0; i < 20; i++) begin
      wait_lvl(1'b0, 2000, hi);
      wait_lvl(1'b1, 2000, lo);
      chk("p10_hi", hi, 651);
      chk("p10_lo", lo, 651);
    end
`ifdef BAUD_GEN_R_TICK_EN
    chk("tick_count", ticks - t0, 20);
`endif

    for (int c = 0; c < 4; c++) begin
      if (c == 2) continue;
      rate = 2'(c);
      do_reset(2);
      wait_lvl(1'b1, 6000, n);
      chk("code_rise", n, per[c] / 2);
      wait_lvl(1'b0, 6000, hi);
      wait_lvl(1'b1, 6000, lo);
      chk("code_period", hi + lo, per[c]);
    end

    rate = 2'd0;
    do_reset(2);
    repeat (2001) step();
    chk("sw_pre", baud_clk, 0);
    rate = 2'd3;
    step();
    chk("sw_toggle", baud_clk, 1);
    wait_lvl(1'b0, 2000, hi);
    wait_lvl(1'b1, 2000, lo);
    chk("sw_period", hi + lo, 650);

    repeat (3) step();
    chk("pre_async", baud_clk, 1);
    #2;
    rst   = 1'b0;
    m_el  = 0;
    m_clk = 1'b0;
    #1;
    chk("async_clk", baud_clk, 0);
    chk("async_cnt", 32'(dut.u_div.cnt_q), 0);
    repeat (2) step();
    rate = 2'd2;
    rst  = 1'b1;
    wait_lvl(1'b1, 2000, n);
    chk("rerise", n, 651);

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0)
        do_reset(int'($urandom_range(1, 3)));
      rate = 2'($urandom_range(0, 3));
      repeat ($urandom_range(50, 500)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_gen_r.md
# baud_gen_r

Receiver-side baud clock generator for the UART. From the single system clock it produces a square-wave `baud_clk` at 16× the selected serial bit rate, which the UART receiver uses to oversample `rx`. It sits beside the transmitter generator `baud_gen_t` (same encoding, 1× rate) and is driven by the same `baud_rate` select.

## Interface
- `CLK_FREQ`, default 200_000_000: system clock frequency in Hz.
- `OVERSAMPLE`, default 16: output clock cycles per serial bit.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `baud_rate`  input  2  rate select: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- `baud_clk`  output  1  square wave at rate × `OVERSAMPLE`, registered.

## Operation
- Full divisor: N = round(`CLK_FREQ` / (rate × `OVERSAMPLE`)).
- Half divisor: H = floor(N/2).
- Defaults give H = 2604, 1302, 651 and 325 for codes 00, 01, 10 and 11.
- Internal counter width is clog2(H_max) bits; 12 bits at the defaults.
- Each clock cycle, while the counter is below H−1, the counter increments.
- When the counter is at or above H−1, it clears to 0 and `baud_clk` toggles on that same edge.
- Each output period is therefore 2·H system cycles, with a 50% duty cycle.
- `baud_rate` is used combinationally each cycle and is not latched.
  - After a change, the next toggle uses the new H.
  - The ≥ compare guarantees that switching to a faster rate never stalls the counter.
- No enable input: the block free-runs whenever `rst` is high.
- H values are computed at elaboration; there is no runtime division.

## Timing
- While `rst` = 0: `baud_clk` = 0 and the counter = 0, immediately (asynchronous).
- After `rst` rises, the first rising edge of `baud_clk` occurs on the H-th rising `clk` edge.
- Thereafter, `baud_clk` edges occur every H cycles.
- Defaults with code 10: H = 651, so the output period is 1302 cycles = 6.51 µs (153.6 kHz ≈ 9600 × 16).
- Asserting reset mid-period drops `baud_clk` to 0 at once. The period restarts from zero on release.
- Output is glitch-free: `baud_clk` is driven directly by a flop.

## Configuration
- `BAUD_GEN_R_TICK_EN` defined:
  - Adds output `baud_tick` (1 bit).
  - One-cycle pulse, high on the cycle in which `baud_clk` is low and about to toggle high.
  - Coincides with the `clk` edge that raises `baud_clk`.
  - Reset value 0.
- Not defined: the port does not exist and the logic is identical otherwise.

## Structure
- Shared package `baud_pkg` holds:
  - Rate-code constants: `BAUD_2400`, `BAUD_4800`, `BAUD_9600`, `BAUD_19200`.
  - A constant function returning H for (`CLK_FREQ`, rate code, oversample).
  - `baud_gen_t` uses this package with oversample 1.
- One natural sub-module: `baud_divider`.
  - Function: counter plus toggle flop with a runtime half-count input.
  - Instantiated by both `baud_gen_r` and `baud_gen_t`; holds all sequential logic.

## Test plan
- Reset hold: `rst` = 0 for 10 cycles with any code → `baud_clk` = 0 throughout; internal counter = 0.
- Code 10 at 200 MHz, release reset:
  - First `baud_clk` rise at clk edge 651.
  - Subsequent period 1302 cycles, high 651 / low 651, measured over 20 periods.
- Each code 00, 01, 11 → measured period 5208, 2604 and 650 cycles respectively.
- Rate switch 00 → 11 mid-count (counter ≈ 2000) → toggle on the next edge (counter ≥ 324); following period 650 cycles.
- Reset asserted asynchronously mid-high phase (between clk edges) → `baud_clk` falls before the next clk edge; after release, first rise after H cycles again.
- With `BAUD_GEN_R_TICK_EN`, code 10 → exactly one `baud_tick` pulse per 1302 cycles, aligned to each `baud_clk` rise.
